ram_port_arbiter: RTL

- Sequences and shares the single-port, synchronous-read data RAM between two requesters: instruction fetch (IF, read-only, always word) and data load/store (D, read/write with byte/half/word access type).
- Latches one request at a time, drives the RAM with registered signals, and captures the read word while the access type is still held.
- Returns the result on a per-port valid/ready response channel.
- Sits between the core's fetch and memory stages and the RAM.

---
 rtl/ram_port_arbiter_if.sv | 47 ++++
 rtl/ram_port_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Request/response channels of the fetch (IF) and load/store (D) ports plus the
// shared single-port RAM bus, as seen by the arbiter (slave) and its environment (master).
interface ram_port_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 14,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     if_req_valid;
  logic                     if_req_ready;
  logic [ADDRESS_WIDTH-1:0] if_addr;
  logic                     if_rsp_valid;
  logic                     if_rsp_ready;
  logic [DATA_WIDTH-1:0]    if_rsp_data;

  logic                     d_req_valid;
  logic                     d_req_ready;
  logic                     d_we;
  logic [ADDRESS_WIDTH-1:0] d_addr;
  logic [2:0]               d_access_type;
  logic [DATA_WIDTH-1:0]    d_wdata;
  logic                     d_rsp_valid;
  logic                     d_rsp_ready;
  logic [DATA_WIDTH-1:0]    d_rsp_data;

  logic                     ram_wEn;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [2:0]               ram_access_type;
  logic [DATA_WIDTH-1:0]    ram_dataIn;
  logic [DATA_WIDTH-1:0]    ram_dataOut;

  modport slave (
    input  if_req_valid, if_addr, if_rsp_ready,
    input  d_req_valid, d_we, d_addr, d_access_type, d_wdata, d_rsp_ready,
    input  ram_dataOut,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output ram_wEn, ram_addr, ram_access_type, ram_dataIn
  );

  modport master (
    output if_req_valid, if_addr, if_rsp_ready,
    output d_req_valid, d_we, d_addr, d_access_type, d_wdata, d_rsp_ready,
    output ram_dataOut,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  ram_wEn, ram_addr, ram_access_type, ram_dataIn
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous-read RAM between instruction fetch and data load/store,
// one transaction at a time: accept, issue, capture, respond.
module ram_port_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 14,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_port_arbiter_if.slave  bus
);

  localparam int unsigned            ACCESS_W    = 3;
  localparam logic [ACCESS_W-1:0]    ACCESS_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic                     r_owner_d;
  logic                     r_last_d;
  logic                     r_we;
  logic                     r_ram_wen;
  logic [ADDRESS_WIDTH-1:0] r_ram_addr;
  logic [ACCESS_W-1:0]      r_ram_access_type;
  logic [DATA_WIDTH-1:0]    r_ram_data_in;
  logic                     r_if_rsp_valid;
  logic                     r_d_rsp_valid;
  logic [DATA_WIDTH-1:0]    r_if_rsp_data;
  logic [DATA_WIDTH-1:0]    r_d_rsp_data;

  logic                     w_if_req_ready;
  logic                     w_d_req_ready;
  logic                     w_accept;
  logic                     w_grant_d;
  logic                     w_capture;
  logic                     w_resp_done;
  logic [DATA_WIDTH-1:0]    w_capture_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state, round-robin grant and datapath strobes
  always_comb begin
    w_state_next   = r_state;
    w_if_req_ready = 1'b0;
    w_d_req_ready  = 1'b0;
    w_accept       = 1'b0;
    w_grant_d      = 1'b0;
    w_capture      = 1'b0;
    w_resp_done    = 1'b0;
    case (r_state)
      IDLE: begin
        // D wins unless IF is also waiting and D was the last one served
        if (bus.d_req_valid && (!bus.if_req_valid || !r_last_d)) begin
          w_d_req_ready = 1'b1;
          w_grant_d     = 1'b1;
          w_accept      = 1'b1;
          w_state_next  = ISSUE;
        end else if (bus.if_req_valid) begin
          w_if_req_ready = 1'b1;
          w_accept       = 1'b1;
          w_state_next   = ISSUE;
        end
      end
      ISSUE:   w_state_next = CAPTURE;
      CAPTURE: begin
        w_capture    = 1'b1;
        w_state_next = RESP;
      end
      RESP: begin
        if (r_owner_d ? bus.d_rsp_ready : bus.if_rsp_ready) begin
          w_resp_done  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_capture_data = r_we ? '0 : bus.ram_dataOut;

  // RAM-driving registers and per-port response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_d         <= 1'b0;
      r_last_d          <= 1'b0;
      r_we              <= 1'b0;
      r_ram_wen         <= 1'b0;
      r_ram_addr        <= '0;
      r_ram_access_type <= '0;
      r_ram_data_in     <= '0;
      r_if_rsp_valid    <= 1'b0;
      r_d_rsp_valid     <= 1'b0;
      r_if_rsp_data     <= '0;
      r_d_rsp_data      <= '0;
    end else begin
      r_ram_wen <= 1'b0;
      if (w_accept) begin
        r_owner_d         <= w_grant_d;
        r_last_d          <= w_grant_d;
        r_we              <= w_grant_d & bus.d_we;
        r_ram_wen         <= w_grant_d & bus.d_we;
        r_ram_addr        <= w_grant_d ? bus.d_addr : bus.if_addr;
        r_ram_access_type <= w_grant_d ? bus.d_access_type : ACCESS_WORD;
        r_ram_data_in     <= w_grant_d ? bus.d_wdata : '0;
      end
      if (w_capture) begin
        if (r_owner_d) begin
          r_d_rsp_data  <= w_capture_data;
          r_d_rsp_valid <= 1'b1;
        end else begin
          r_if_rsp_data  <= w_capture_data;
          r_if_rsp_valid <= 1'b1;
        end
      end
      if (w_resp_done) begin
        r_if_rsp_valid <= 1'b0;
        r_d_rsp_valid  <= 1'b0;
      end
    end
  end

  assign bus.if_req_ready    = w_if_req_ready;
  assign bus.d_req_ready     = w_d_req_ready;
  assign bus.if_rsp_valid    = r_if_rsp_valid;
  assign bus.if_rsp_data     = r_if_rsp_data;
  assign bus.d_rsp_valid     = r_d_rsp_valid;
  assign bus.d_rsp_data      = r_d_rsp_data;
  assign bus.ram_wEn         = r_ram_wen;
  assign bus.ram_addr        = r_ram_addr;
  assign bus.ram_access_type = r_ram_access_type;
  assign bus.ram_dataIn      = r_ram_data_in;

endmodule
